// File: rtl/apb_event_pkg.sv
// rtl/apb_event_pkg.sv - register map constants for the APB event unit
package apb_event_pkg;

  localparam logic [4:0] OFF_MASK    = 5'h00;
  localparam logic [4:0] OFF_PENDING = 5'h04;
  localparam logic [4:0] OFF_PSET    = 5'h08;
  localparam logic [4:0] OFF_PCLR    = 5'h0C;
  localparam logic [4:0] OFF_TYPE    = 5'h10;
  localparam logic [4:0] OFF_ID      = 5'h14;

  localparam int ID_VALID_BIT = 31;

  // Registers are decoded on the word index only; byte lanes are ignored.
  function automatic logic [2:0] word_idx(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/apb_event_prio_enc.sv
// rtl/apb_event_prio_enc.sv - lowest-index-wins priority encoder
module apb_event_prio_enc #(
  parameter int NUM_EVT  = 32,
  parameter int ID_WIDTH = 5
) (
  input  logic [NUM_EVT-1:0]  req,
  output logic                valid,
  output logic [ID_WIDTH-1:0] id
);

  // Scan from the top so the last hit, the lowest index, is the one kept.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NUM_EVT - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/apb_event_unit.sv
// rtl/apb_event_unit.sv - APB event collector: sticky pending, mask, prioritised irq with ack
module apb_event_unit #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_EVT        = 32,
  parameter int ID_WIDTH       = 5
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_EVT-1:0]        evt_i,
  output logic                      irq_req_o,
  output logic [ID_WIDTH-1:0]       irq_id_o,
  input  logic                      irq_ack_i,
  input  logic [ID_WIDTH-1:0]       irq_ack_id_i
);
  import apb_event_pkg::*;

  logic [NUM_EVT-1:0]  mask_q;
  logic [NUM_EVT-1:0]  pend_q;
  logic [NUM_EVT-1:0]  type_q;
  logic [NUM_EVT-1:0]  evt_q;
  logic [NUM_EVT-1:0]  pend_next;
  logic [NUM_EVT-1:0]  wdata;
  logic [NUM_EVT-1:0]  pset;
  logic [NUM_EVT-1:0]  pclr;
  logic [NUM_EVT-1:0]  ack_bits;
  logic [NUM_EVT-1:0]  hw_set;
  logic                wr_en;
  logic                rd_en;
  logic [2:0]          widx;
  logic                prio_valid;
  logic [ID_WIDTH-1:0] prio_id;
  logic [31:0]         id_word;
  logic                unused_bits;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  assign wr_en = PSEL & PENABLE & PWRITE;
  assign rd_en = PSEL & PENABLE & ~PWRITE;
  assign widx  = PADDR[4:2];
  assign wdata = PWDATA[NUM_EVT-1:0];

  assign unused_bits = ^{PADDR, PWDATA};

  assign pset = (wr_en && widx == word_idx(OFF_PSET)) ? wdata : '0;
  assign pclr = (wr_en && widx == word_idx(OFF_PCLR)) ? wdata : '0;

  always_comb begin
    ack_bits = '0;
    if (irq_ack_i && int'(irq_ack_id_i) < NUM_EVT)
      ack_bits = NUM_EVT'(1) << irq_ack_id_i;
  end

  // Edge-typed bits compare against last cycle's sample; level bits pend while high.
  assign hw_set = (type_q & evt_i & ~evt_q) | (~type_q & evt_i);

  // Sets are OR-ed in after the clear so a new event is never lost.
  assign pend_next = (pend_q & ~(pclr | ack_bits)) | hw_set | pset;

  apb_event_prio_enc #(
    .NUM_EVT  (NUM_EVT),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio (
    .req   (pend_q & mask_q),
    .valid (prio_valid),
    .id    (prio_id)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      mask_q    <= '0;
      pend_q    <= '0;
      type_q    <= '0;
      evt_q     <= '0;
      irq_req_o <= 1'b0;
      irq_id_o  <= '0;
    end else begin
      pend_q    <= pend_next;
      evt_q     <= evt_i;
      irq_req_o <= prio_valid;
      irq_id_o  <= prio_id;
      if (wr_en && widx == word_idx(OFF_MASK)) mask_q <= wdata;
      if (wr_en && widx == word_idx(OFF_TYPE)) type_q <= wdata;
    end
  end

  always_comb begin
    id_word                  = '0;
    id_word[ID_VALID_BIT]    = prio_valid;
    id_word[ID_WIDTH-1:0]    = prio_id;
  end

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (widx)
        word_idx(OFF_MASK):    PRDATA = 32'(mask_q);
        word_idx(OFF_PENDING): PRDATA = 32'(pend_q);
        word_idx(OFF_TYPE):    PRDATA = 32'(type_q);
        word_idx(OFF_ID):      PRDATA = id_word;
        default:               PRDATA = '0;
      endcase
    end
  end

endmodule
